axis_lane_adder_pipe: RTL and testbench
=======================================

Name: axis_lane_adder_pipe

Overview:
- Parametrised successor to the single-mode AXI4-Stream lane adder.
- Splits each beat into C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH integer lanes and applies a per-beat selectable operation: wrap add, saturating add, per-packet accumulate or pass-through.
- Uses a configurable-depth arithmetic pipeline and an internal output FIFO with credit-based backpressure, so full throughput never depends on a lagging prog_full.
- Sits between the read-master stream and the write-master stream inside the RTL kernel.

Parameters:
- C_AXIS_TDATA_WIDTH, 512: stream data width; must be a multiple of C_ADDER_BIT_WIDTH.
- C_ADDER_BIT_WIDTH, 32: lane width, 8..64.
- C_PIPE_STAGES, 2: register stages after the operation stage, 1..8.
- C_FIFO_DEPTH, 16: output FIFO entries; power of 2, at least C_PIPE_STAGES+2.

Ports:
- s_axis_aclk  in  1  only clock; both streams are synchronous to it.
- s_axis_areset  in  1  synchronous, active-high reset.
- ctrl_constant  in  C_ADDER_BIT_WIDTH  addend for modes 0 and 1.
- ctrl_mode  in  2  0=wrap add, 1=signed saturating add, 2=accumulate, 3=pass-through.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  input lanes; lane i occupies bits [i*W +: W].
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8  byte keep; carried alongside the beat.
- s_axis_tlast  in  1  packet end.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  result lanes.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  copy of the input tkeep for the same beat.
- m_axis_tlast  out  1  copy of the input tlast for the same beat.
- stat_beats  out  32  count of completed output handshakes; wraps modulo 2^32.

Behaviour:
- Reset, synchronous and active-high: clears FIFO, pipeline valid bits, credit counter, lane accumulators and stat_beats. s_axis_tready=0 and m_axis_tvalid=0 during reset; s_axis_tready=1 the cycle after reset deasserts. Reset mid-packet drops all in-flight beats and leaves no partial accumulation.
- Accept: a beat is accepted when s_axis_tvalid & s_axis_tready. ctrl_mode and ctrl_constant are sampled with the beat, so a mid-stream change applies from the next accepted beat onward.
- Credits: inflight counts beats in the pipeline plus FIFO occupancy, 0..C_FIFO_DEPTH. It increments on accept and decrements on output handshake; a simultaneous accept and handshake leaves it unchanged. s_axis_tready = (inflight < C_FIFO_DEPTH), registered-equivalent with no combinational path from m_axis_tready.
- Pipeline: never stalls. Every accepted beat is guaranteed a FIFO slot, so a FIFO write-when-full is impossible; the bench asserts on it.
- Latency: accept at cycle t gives m_axis_tvalid at t+C_PIPE_STAGES+1 when the FIFO is empty. Sustained throughput is 1 beat/cycle while m_axis_tready=1.
- Mode 0: lane = (d + c) mod 2^W.
- Mode 1: signed two's-complement add, clamped to [-2^(W-1), 2^(W-1)-1].
- Mode 2: per-lane accumulator acc_i <= acc_i + d_i, wrapping; the output lane is the updated acc_i. All acc_i clear to 0 after a mode-2 beat with tlast=1, and on any accepted non-mode-2 beat. Back-to-back mode-2 beats must chain with no bubble.
- Mode 3: lane = d.
- tkeep does not gate arithmetic; every lane is computed and tkeep is forwarded unchanged.
- FIFO: first-word-fall-through. m_axis_tdata, tkeep and tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0. Empty gives m_axis_tvalid=0. Full gives s_axis_tready=0.
- Pointers: binary with wrap at C_FIFO_DEPTH. Simultaneous read and write when full or empty is handled without loss.
- stat_beats increments on each m_axis_tvalid & m_axis_tready.

Test Plan (C_AXIS_TDATA_WIDTH=64, C_ADDER_BIT_WIDTH=32, C_PIPE_STAGES=2, C_FIFO_DEPTH=8):
- Wrap: mode 0, constant 1, beat {0xFFFFFFFF, 0x00000005} -> output {0x00000000, 0x00000006} exactly 3 cycles after accept.
- Saturate: mode 1, constant 0x7FFFFFF0, beat {0x00000100, 0xFFFFFFFF} -> {0x7FFFFFFF, 0x7FFFFFEF}; constant 0x80000000 with lane 0xFFFFFFFF -> 0x80000000.
- Accumulate: mode 2, beats {1,2}, {3,4}, {5,6} with tlast on the third, then {7,8} -> outputs {1,2}, {4,6}, {9,12}, {7,8}, all beats accepted back-to-back.
- Backpressure: m_axis_tready=0 while streaming 20 beats -> s_axis_tready falls after exactly 8 accepts. Release -> all 20 beats in order, no loss or duplication, stat_beats=20.
- Random: randomly toggle tvalid and tready for 10,000 beats with random modes -> matches reference model, tkeep/tlast aligned, no FIFO overflow assertion.
- Reset: assert s_axis_areset after 3 beats of a mode-2 packet -> m_axis_tvalid=0 the next cycle, stat_beats=0. The following mode-2 beat {2,2} outputs {2,2}.

Source files
------------

// File: rtl/axis_lane_adder_pipe.sv
// AXI4-Stream lane adder: per-beat wrap/saturating add, per-packet accumulate or
// pass-through, followed by a fixed-depth pipeline and a credit-protected FWFT output FIFO.
module axis_lane_adder_pipe #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_PIPE_STAGES      = 2,
  parameter int C_FIFO_DEPTH       = 16
) (
  input  logic                              s_axis_aclk,
  input  logic                              s_axis_areset,
  input  logic [C_ADDER_BIT_WIDTH-1:0]      ctrl_constant,
  input  logic [1:0]                        ctrl_mode,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [31:0]                       stat_beats
);

  localparam int W         = C_ADDER_BIT_WIDTH;
  localparam int NUM_LANES = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
  localparam int KW        = C_AXIS_TDATA_WIDTH / 8;
  localparam int P         = C_PIPE_STAGES;
  localparam int AW        = $clog2(C_FIFO_DEPTH);
  localparam int CW        = $clog2(C_FIFO_DEPTH + 1);
  localparam int FW        = C_AXIS_TDATA_WIDTH + KW + 1;

  localparam logic [1:0] MODE_WRAP = 2'd0;
  localparam logic [1:0] MODE_SAT  = 2'd1;
  localparam logic [1:0] MODE_ACC  = 2'd2;

  logic          accept;
  logic          m_hs;
  logic [CW-1:0] inflight;
  logic          fifo_empty;

  // Credits cover pipeline plus FIFO, so readiness depends only on registered state.
  assign s_axis_tready = ~s_axis_areset & (inflight < CW'(C_FIFO_DEPTH));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = ~s_axis_areset & ~fifo_empty;
  assign m_hs          = m_axis_tvalid & m_axis_tready;

  // ---------------- operation stage ----------------
  logic [NUM_LANES-1:0][W-1:0] lane_in;
  logic [NUM_LANES-1:0][W-1:0] acc_q;
  logic [NUM_LANES-1:0][W-1:0] op_res;

  assign lane_in = s_axis_tdata;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum[W] != sum[W-1])
      return sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return sum[W-1:0];
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
    op_res = lane_in;
    for (int i = 0; i < NUM_LANES; i++) begin
      case (ctrl_mode)
        MODE_WRAP: op_res[i] = lane_in[i] + ctrl_constant;
        MODE_SAT:  op_res[i] = sat_add(lane_in[i], ctrl_constant);
        MODE_ACC:  op_res[i] = lane_in[i] + acc_q[i];
        default:   op_res[i] = lane_in[i];
      endcase
    end
  end

  // Accumulators keep running only across mode-2 beats of the same packet.
  always_ff @(posedge s_axis_aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (s_axis_areset)
      acc_q <= '0;
    else if (accept) begin
      if (ctrl_mode == MODE_ACC && !s_axis_tlast)
        acc_q <= op_res;
      else
        acc_q <= '0;
    end
  end

  // ---------------- register pipeline ----------------
  logic [P-1:0]                               pipe_valid;
  logic [P-1:0][C_AXIS_TDATA_WIDTH-1:0]       pipe_data;
  logic [P-1:0][KW-1:0]                       pipe_keep;
  logic [P-1:0]                               pipe_last;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset)
      pipe_valid <= '0;
    else begin
      pipe_valid[0] <= accept;
      for (int s = 1; s < P; s++)
        pipe_valid[s] <= pipe_valid[s-1];
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    pipe_data[0] <= op_res;
    pipe_keep[0] <= s_axis_tkeep;
    pipe_last[0] <= s_axis_tlast;
    for (int s = 1; s < P; s++) begin
      pipe_data[s] <= pipe_data[s-1];
      pipe_keep[s] <= pipe_keep[s-1];
      pipe_last[s] <= pipe_last[s-1];
    end
  end

  // ---------------- output FIFO (first-word-fall-through) ----------------
  logic [FW-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_wr;
  logic          fifo_rd;

  assign fifo_wr    = pipe_valid[P-1];
  assign fifo_rd    = m_hs;
  assign fifo_empty = (fifo_cnt == '0);

  always_ff @(posedge s_axis_aclk) begin
    // NOTE: storage is not reset; pointers and count define which entries are valid.
    if (fifo_wr)
      mem[wr_ptr] <= {pipe_last[P-1], pipe_keep[P-1], pipe_data[P-1]};
  end

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem[rd_ptr];

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- credits and statistics ----------------
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      inflight   <= '0;
      stat_beats <= '0;
    end else begin
      case ({accept, m_hs})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (m_hs)
        stat_beats <= stat_beats + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_lane_adder_pipe.sv
// Scoreboard bench for axis_lane_adder_pipe: directed scenarios plus a long random run
// against an independent lane model.
module tb_axis_lane_adder_pipe;

  localparam int TD = 64;
  localparam int W  = 32;
  localparam int P  = 2;
  localparam int D  = 8;

  typedef struct packed {
    logic [TD-1:0]   data;
    logic [TD/8-1:0] keep;
    logic            last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    c_const;
  logic [1:0]      c_mode;
  logic            s_valid;
  logic            s_ready;
  logic [TD-1:0]   s_data;
  logic [TD/8-1:0] s_keep;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [TD-1:0]   m_data;
  logic [TD/8-1:0] m_keep;
  logic            m_last;
  logic [31:0]     stat;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t sb[$];
  beat_t out_log[$];
  logic [W-1:0] m_acc [TD/W];

  always #5 clk = ~clk;

  axis_lane_adder_pipe #(
    .C_AXIS_TDATA_WIDTH(TD), .C_ADDER_BIT_WIDTH(W),
    .C_PIPE_STAGES(P), .C_FIFO_DEPTH(D)
  ) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .ctrl_constant(c_const), .ctrl_mode(c_mode),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .stat_beats(stat)
  );

  // Reference model for one accepted beat; updates the model accumulators.
  function automatic beat_t model_beat(input logic [1:0] mode, input logic [W-1:0] cst,
                                       input logic [TD-1:0] d, input logic [TD/8-1:0] k,
                                       input logic l);
    beat_t  r;
    longint s;
    longint hi = (longint'(1) <<< (W-1)) - 1;
    longint lo = -(longint'(1) <<< (W-1));
    logic [W-1:0] lane;
    r.keep = k;
    r.last = l;
    r.data = '0;
    for (int i = 0; i < TD/W; i++) begin
      lane = d[i*W +: W];
      case (mode)
        2'd0: r.data[i*W +: W] = lane + cst;
        2'd1: begin
          s = longint'($signed(lane)) + longint'($signed(cst));
          if (s > hi)      r.data[i*W +: W] = hi[W-1:0];
          else if (s < lo) r.data[i*W +: W] = lo[W-1:0];
          else             r.data[i*W +: W] = s[W-1:0];
        end
        2'd2: begin
          r.data[i*W +: W] = m_acc[i] + lane;
          m_acc[i] = l ? '0 : r.data[i*W +: W];
        end
        default: r.data[i*W +: W] = lane;
      endcase
      if (mode != 2'd2) m_acc[i] = '0;
    end
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    beat_t got, exp_b;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < TD/W; i++) m_acc[i] = '0;
    end else begin
      if (m_valid && m_ready) begin
        got = '{data: m_data, keep: m_keep, last: m_last};
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected got=%h exp=<none>", got);
        end else begin
          exp_b = sb.pop_front();
          if (got !== exp_b) begin
            miscompares++;
            $display("FAIL sb_beat got=%h exp=%h", got, exp_b);
          end
        end
        out_log.push_back(got);
      end
      if (s_valid && s_ready)
        sb.push_back(model_beat(c_mode, c_const, s_data, s_keep, s_last));
    end
  end

  always @(negedge clk) begin
    if (!rst && dut.fifo_wr && dut.fifo_cnt == D) begin
      miscompares++;
      $display("FAIL fifo_overflow cnt=%0d exp=<%0d", dut.fifo_cnt, D);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic beat_t log_at(input int i);
    if (i < out_log.size()) return out_log[i];
    return 'x;
  endfunction

  task automatic send(input logic [1:0] mode, input logic [W-1:0] cst, input logic [TD-1:0] d,
                      input logic [TD/8-1:0] k, input logic l, output int stalls);
    stalls  = 0;
    c_mode  = mode;
    c_const = cst;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready) begin
      stalls++;
      if (stalls > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout got=stalled exp=accept");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_drain got=%0d pending exp=0", name, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    c_mode = 2'd0; c_const = '0; s_data = '0; s_keep = '0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors += 3;
    if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_tready got=%b exp=0", s_ready); end
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid got=%b exp=0", m_valid); end
    if (stat !== 32'd0)   begin miscompares++; $display("FAIL rst_stat got=%0d exp=0", stat); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_tready got=%b exp=1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic exp_v;
    m_ready = 1'b1;
    out_log.delete();
    c_mode = 2'd0; c_const = 32'd1;
    s_data = {32'hFFFF_FFFF, 32'h0000_0005}; s_keep = 8'hA5; s_last = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1) begin miscompares++; $display("FAIL wrap_accept got=%b exp=1", s_ready); end
    @(posedge clk); #1 s_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      exp_v = (k == 3);
      vectors++;
      if (m_valid !== exp_v) begin
        miscompares++;
        $display("FAIL wrap_latency_c%0d got=%b exp=%b", k, m_valid, exp_v);
      end
    end
    vectors++;
    if (m_data !== 64'h0000_0000_0000_0006) begin
      miscompares++;
      $display("FAIL wrap_data got=%h exp=%h", m_data, 64'h0000_0000_0000_0006);
    end
    wait_drain("wrap");
  endtask

  task automatic test_saturate();
    int st;
    out_log.delete();
    m_ready = 1'b1;
    send(2'd1, 32'h7FFF_FFF0, {32'h0000_0100, 32'hFFFF_FFFF}, 8'hFF, 1'b0, st);
    send(2'd1, 32'h8000_0000, {32'hFFFF_FFFF, 32'h0000_0000}, 8'hFF, 1'b1, st);
    wait_drain("sat");
    vectors += 2;
    if (log_at(0).data !== 64'h7FFF_FFFF_7FFF_FFEF) begin
      miscompares++;
      $display("FAIL sat_pos got=%h exp=%h", log_at(0).data, 64'h7FFF_FFFF_7FFF_FFEF);
    end
    if (log_at(1).data !== 64'h8000_0000_8000_0000) begin
      miscompares++;
      $display("FAIL sat_neg got=%h exp=%h", log_at(1).data, 64'h8000_0000_8000_0000);
    end
  endtask

  task automatic test_accumulate();
    int st, total;
    logic [TD-1:0] exp_d [4];
    exp_d[0] = {32'd1, 32'd2};
    exp_d[1] = {32'd4, 32'd6};
    exp_d[2] = {32'd9, 32'd12};
    exp_d[3] = {32'd7, 32'd8};
    out_log.delete();
    m_ready = 1'b1;
    total = 0;
    send(2'd2, '0, {32'd1, 32'd2}, 8'hFF, 1'b0, st); total += st;
    send(2'd2, '0, {32'd3, 32'd4}, 8'hFF, 1'b0, st); total += st;
    send(2'd2, '0, {32'd5, 32'd6}, 8'hFF, 1'b1, st); total += st;
    send(2'd2, '0, {32'd7, 32'd8}, 8'hFF, 1'b0, st); total += st;
    wait_drain("acc");
    vectors++;
    if (total !== 0) begin miscompares++; $display("FAIL acc_back_to_back got=%0d stalls exp=0", total); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (log_at(i).data !== exp_d[i]) begin
        miscompares++;
        $display("FAIL acc_beat%0d got=%h exp=%h", i, log_at(i).data, exp_d[i]);
      end
    end
    vectors++;
    if (log_at(2).last !== 1'b1) begin miscompares++; $display("FAIL acc_tlast got=%b exp=1", log_at(2).last); end
    // Close the packet so later tests start from clear accumulators.
    send(2'd3, '0, '0, 8'hFF, 1'b1, st);
    wait_drain("acc_close");
  endtask

  task automatic test_backpressure();
    int idx = 0, accepted = 0, guard = 0;
    logic acc_now;
    apply_reset();
    out_log.delete();
    m_ready = 1'b0;
    c_mode = 2'd3; c_const = '0; s_keep = 8'hFF; s_last = 1'b0;
    s_data = 64'd0; s_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc_now = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        accepted++; idx++; s_data = 64'(idx); s_last = (idx == 19);
        if (idx == 20) s_valid = 1'b0;
      end
    end
    vectors += 2;
    if (accepted !== D) begin miscompares++; $display("FAIL bp_accepts got=%0d exp=%0d", accepted, D); end
    if (s_ready !== 1'b0) begin miscompares++; $display("FAIL bp_tready got=%b exp=0", s_ready); end
    m_ready = 1'b1;
    while (idx < 20 && guard < 200) begin
      @(negedge clk);
      acc_now = s_valid && s_ready;
      @(posedge clk); #1;
      guard++;
      if (acc_now) begin
        idx++; s_data = 64'(idx); s_last = (idx == 19);
        if (idx == 20) s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    wait_drain("bp");
    vectors += 2;
    if (out_log.size() !== 20) begin miscompares++; $display("FAIL bp_count got=%0d exp=20", out_log.size()); end
    if (stat !== 32'd20) begin miscompares++; $display("FAIL bp_stat got=%0d exp=20", stat); end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (log_at(i).data !== 64'(i)) begin
        miscompares++;
        $display("FAIL bp_order%0d got=%h exp=%h", i, log_at(i).data, 64'(i));
      end
    end
  endtask

  function automatic logic [W-1:0] rand_lane();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int sent = 0, cycles = 0;
    logic acc_now;
    out_log.delete();
    s_valid = 1'b0;
    while (sent < 10000 && cycles < 60000) begin
      @(negedge clk);
      acc_now = s_valid && s_ready;
      @(posedge clk); #1;
      cycles++;
      if (acc_now) sent++;
      m_ready = ($urandom_range(0, 3) != 0);
      if (acc_now || !s_valid) begin
        s_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
        c_mode  = 2'($urandom_range(0, 3));
        c_const = rand_lane();
        s_data  = {rand_lane(), rand_lane()};
        s_keep  = 8'($urandom);
        s_last  = ($urandom_range(0, 3) == 0);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_drain("rand");
    vectors++;
    if (sent !== 10000) begin miscompares++; $display("FAIL rand_sent got=%0d exp=10000", sent); end
  endtask

  task automatic test_midpacket_reset();
    int st;
    m_ready = 1'b0;
    send(2'd2, '0, {32'd1, 32'd1}, 8'hFF, 1'b0, st);
    send(2'd2, '0, {32'd1, 32'd1}, 8'hFF, 1'b0, st);
    send(2'd2, '0, {32'd1, 32'd1}, 8'hFF, 1'b0, st);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors += 2;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_tvalid got=%b exp=0", m_valid); end
    if (stat !== 32'd0) begin miscompares++; $display("FAIL mrst_stat got=%0d exp=0", stat); end
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    m_ready = 1'b1;
    out_log.delete();
    send(2'd2, '0, {32'd2, 32'd2}, 8'hFF, 1'b0, st);
    wait_drain("mrst");
    vectors += 2;
    if (out_log.size() !== 1) begin miscompares++; $display("FAIL mrst_count got=%0d exp=1", out_log.size()); end
    if (log_at(0).data !== {32'd2, 32'd2}) begin
      miscompares++;
      $display("FAIL mrst_data got=%h exp=%h", log_at(0).data, {32'd2, 32'd2});
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_accumulate();
    test_backpressure();
    test_random();
    test_midpacket_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
